// File: rtl/camera_pkg.sv
// Shared state encoding and table-entry constants for the camera configuration sequencer.
package camera_pkg;

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] FETCH     = 4'd1;
  localparam logic [3:0] DECODE    = 4'd2;
  localparam logic [3:0] ISSUE     = 4'd3;
  localparam logic [3:0] WAIT_ACK  = 4'd4;
  localparam logic [3:0] WAIT_DONE = 4'd5;
  localparam logic [3:0] DELAY     = 4'd6;
  localparam logic [3:0] NEXT      = 4'd7;
  localparam logic [3:0] DONE      = 4'd8;

  localparam logic [15:0] END_MARK  = 16'hFFFF;
  localparam logic [7:0]  DELAY_TAG = 8'hF0;

  typedef enum logic [1:0] {
    ENTRY_WRITE,
    ENTRY_DELAY,
    ENTRY_END
  } entry_kind_e;

  function automatic entry_kind_e classify_entry(input logic [15:0] entry);
    entry_kind_e kind;
    kind = ENTRY_WRITE;
    if (entry == END_MARK)
      kind = ENTRY_END;
    else if (entry[15:8] == DELAY_TAG)
      kind = ENTRY_DELAY;
    return kind;
  endfunction

endpackage

// File: rtl/camera_config_sequencer_seq_timer.sv
// Loadable down-counter with zero flag; one instance serves the delay and both timeouts.
module seq_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (enable && count != '0)
      count <= count - WIDTH'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/camera_config_sequencer.sv
// Walks the OV7670 register table and hands each write to the SCCB engine one at a time.
// Delay entries pause the walk; a missing ACK, a stuck transfer or a table overrun abort with ERROR.
module camera_config_sequencer
  import camera_pkg::*;
#(
  parameter int ROM_ADDR_W   = 8,
  parameter int DELAY_CYCLES = 12000,
  parameter int ACK_TIMEOUT  = 64,
  parameter int XFER_TIMEOUT = 65535
) (
  input  logic                  GLOBAL_CLK,
  input  logic                  RESET,
  input  logic                  START,
  output logic [ROM_ADDR_W-1:0] ROM_ADDR,
  input  logic [15:0]           ROM_DATA,
  output logic                  I2C_START,
  output logic [7:0]            I2C_SUBADDR,
  output logic [7:0]            I2C_VALUE,
  input  logic                  I2C_READY,
  output logic                  BUSY,
  output logic                  CONFIG_FINISHED,
  output logic                  ERROR,
  output logic [7:0]            WRITE_COUNT
);

  localparam int DELAY_MAX = 255 * DELAY_CYCLES;
  localparam int WAIT_MAX  = (XFER_TIMEOUT > ACK_TIMEOUT) ? XFER_TIMEOUT : ACK_TIMEOUT;
  localparam int TIMER_MAX = (DELAY_MAX > WAIT_MAX) ? DELAY_MAX : WAIT_MAX;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  logic [3:0]         state;
  entry_kind_e        entry_kind;
  logic               timer_load;
  logic               timer_en;
  logic               timer_zero;
  logic [TIMER_W-1:0] timer_value;
  logic [TIMER_W-1:0] delay_value;

  assign entry_kind  = classify_entry(ROM_DATA);
  assign delay_value = TIMER_W'(ROM_DATA[7:0]) * TIMER_W'(DELAY_CYCLES) - TIMER_W'(1);
  assign timer_en    = (state == WAIT_ACK) || (state == WAIT_DONE) || (state == DELAY);

  // Timer is loaded with N-1 on the edge that enters the timed state, so the state lasts N cycles.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      DECODE:
        if (entry_kind == ENTRY_DELAY && ROM_DATA[7:0] != 8'h00) begin
          timer_load  = 1'b1;
          timer_value = delay_value;
        end
      ISSUE:
        if (I2C_READY) begin
          timer_load  = 1'b1;
          timer_value = TIMER_W'(ACK_TIMEOUT - 1);
        end
      WAIT_ACK:
        if (!I2C_READY) begin
          timer_load  = 1'b1;
          timer_value = TIMER_W'(XFER_TIMEOUT - 1);
        end
      default: ;
    endcase
  end

  seq_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk        (GLOBAL_CLK),
    .reset      (RESET),
    .load       (timer_load),
    .load_value (timer_value),
    .enable     (timer_en),
    .zero       (timer_zero)
  );

  always_ff @(posedge GLOBAL_CLK) begin
    if (RESET) begin
      state           <= IDLE;
      ROM_ADDR        <= '0;
      I2C_START       <= 1'b0;
      I2C_SUBADDR     <= 8'h00;
      I2C_VALUE       <= 8'h00;
      BUSY            <= 1'b0;
      CONFIG_FINISHED <= 1'b0;
      ERROR           <= 1'b0;
      WRITE_COUNT     <= 8'h00;
    end else begin
      I2C_START <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (START) begin
            ROM_ADDR        <= '0;
            CONFIG_FINISHED <= 1'b0;
            ERROR           <= 1'b0;
            WRITE_COUNT     <= 8'h00;
            BUSY            <= 1'b1;
            state           <= FETCH;
          end
        end
        FETCH: state <= DECODE;
        DECODE:
          case (entry_kind)
            ENTRY_END: begin
              state           <= DONE;
              BUSY            <= 1'b0;
              CONFIG_FINISHED <= 1'b1;
            end
            ENTRY_DELAY: state <= (ROM_DATA[7:0] == 8'h00) ? NEXT : DELAY;
            default: begin
              I2C_SUBADDR <= ROM_DATA[15:8];
              I2C_VALUE   <= ROM_DATA[7:0];
              state       <= ISSUE;
            end
          endcase
        ISSUE:
          if (I2C_READY) begin
            I2C_START <= 1'b1;
            state     <= WAIT_ACK;
          end
        WAIT_ACK:
          if (!I2C_READY) begin
            state <= WAIT_DONE;
          end else if (timer_zero) begin
            state           <= DONE;
            BUSY            <= 1'b0;
            CONFIG_FINISHED <= 1'b1;
            ERROR           <= 1'b1;
          end
        WAIT_DONE:
          if (I2C_READY) begin
            if (WRITE_COUNT != 8'hFF)
              WRITE_COUNT <= WRITE_COUNT + 8'd1;
            state <= NEXT;
          end else if (timer_zero) begin
            state           <= DONE;
            BUSY            <= 1'b0;
            CONFIG_FINISHED <= 1'b1;
            ERROR           <= 1'b1;
          end
        DELAY:
          if (timer_zero)
            state <= NEXT;
        NEXT:
          if (ROM_ADDR == '1) begin
            state           <= DONE;
            BUSY            <= 1'b0;
            CONFIG_FINISHED <= 1'b1;
            ERROR           <= 1'b1;
          end else begin
            ROM_ADDR <= ROM_ADDR + ROM_ADDR_W'(1);
            state    <= FETCH;
          end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_config_sequencer.sv
// Bench for camera_config_sequencer: a timeline model predicts pulse, busy, flag and count cycles
// from the table rules and the I2C responder timing; a per-cycle compare checks the DUT against it.
module tb_camera_config_sequencer;

  localparam int AW      = 2;
  localparam int DC      = 4;
  localparam int ACK_TO  = 8;
  localparam int XFER_TO = 32;

  logic          clk = 1'b0;
  logic          rst, start, i2c_start, busy, fin, err;
  logic          ready_model, stall, i2c_ready;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic [7:0]    sub, val, wcount;
  logic [15:0]   tbl [4];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // Timeline model of the current run, in absolute cycle numbers.
  bit          model_on = 1'b0;
  int          run_s = 1 << 30;
  int          run_done = 0;
  bit          run_err = 1'b0;
  int          n_p = 0;
  int          n_comp = 0;
  int          p_cyc [4];
  logic [15:0] p_ent [4];
  int          comp_cyc [4];
  int          prev_fin = 0, prev_err = 0, prev_cnt = 0;
  int          i2c_mode = 0;

  assign i2c_ready = ready_model & ~stall;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= tbl[rom_addr];

  camera_config_sequencer #(
    .ROM_ADDR_W  (AW),
    .DELAY_CYCLES(DC),
    .ACK_TIMEOUT (ACK_TO),
    .XFER_TIMEOUT(XFER_TO)
  ) dut (
    .GLOBAL_CLK     (clk),
    .RESET          (rst),
    .START          (start),
    .ROM_ADDR       (rom_addr),
    .ROM_DATA       (rom_data),
    .I2C_START      (i2c_start),
    .I2C_SUBADDR    (sub),
    .I2C_VALUE      (val),
    .I2C_READY      (i2c_ready),
    .BUSY           (busy),
    .CONFIG_FINISHED(fin),
    .ERROR          (err),
    .WRITE_COUNT    (wcount)
  );

  // I2C responder: READY low 2 cycles after the pulse for 10 cycles; mode 1 never acks, mode 2 hangs.
  initial begin
    ready_model = 1'b1;
    forever begin
      @(negedge clk);
      if (i2c_start === 1'b1 && i2c_mode != 1) begin
        @(negedge clk);
        @(negedge clk);
        ready_model = 1'b0;
        repeat ((i2c_mode == 2) ? 40 : 10) @(negedge clk);
        ready_model = 1'b1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Cycle k is the state after rising edge k. START sampled at edge s enters FETCH at s.
  task automatic build_model(input int s, input int r, input int mode);
    int f, nxt, p;
    bit first_w, stop;
    logic [15:0] e;
    f = s; nxt = s; n_p = 0; n_comp = 0; run_err = 1'b0; run_done = 0; first_w = 1'b1; stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!stop) begin
        e = tbl[i];
        if (e == 16'hFFFF) begin
          run_done = f + 2;
          stop = 1'b1;
        end else begin
          if (e[15:8] == 8'hF0) begin
            nxt = f + 3 + int'(e[7:0]) * DC;
          end else begin
            p = f + 3;
            if (first_w && r > p) p = r;
            first_w = 1'b0;
            p_cyc[n_p] = p;
            p_ent[n_p] = e;
            n_p++;
            if (mode == 1) begin
              run_done = p + ACK_TO; run_err = 1'b1; stop = 1'b1;
            end else if (mode == 2) begin
              run_done = p + 3 + XFER_TO; run_err = 1'b1; stop = 1'b1;
            end else begin
              comp_cyc[n_comp] = p + 13;
              n_comp++;
              nxt = p + 14;
            end
          end
          if (!stop && i == 3) begin
            run_done = nxt; run_err = 1'b1; stop = 1'b1;
          end
          f = nxt;
        end
      end
    end
    run_s = s;
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (model_on) begin
        int k, e_start, e_busy, e_fin, e_err, e_cnt;
        k = cyc;
        e_start = 0;
        if (k < run_s) begin
          e_busy = 0; e_fin = prev_fin; e_err = prev_err; e_cnt = prev_cnt;
        end else begin
          e_busy = (k < run_done) ? 1 : 0;
          e_fin  = (k >= run_done) ? 1 : 0;
          e_err  = (e_fin == 1 && run_err) ? 1 : 0;
          e_cnt  = 0;
          for (int j = 0; j < n_comp; j++)
            if (comp_cyc[j] <= k) e_cnt++;
          for (int j = 0; j < n_p; j++) begin
            if (p_cyc[j] == k) e_start = 1;
            if (k >= p_cyc[j] && k <= p_cyc[j] + 13 && k < run_done) begin
              check("subaddr", sub, p_ent[j][15:8]);
              check("value", val, p_ent[j][7:0]);
            end
          end
        end
        check("i2c_start", i2c_start, e_start);
        check("busy", busy, e_busy);
        check("finished", fin, e_fin);
        check("error", err, e_err);
        check("write_count", wcount, e_cnt);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_finished"}, fin, 0);
    check({tag, "_error"}, err, 0);
    check({tag, "_count"}, wcount, 0);
    check({tag, "_i2c_start"}, i2c_start, 0);
    check({tag, "_subaddr"}, sub, 0);
    check({tag, "_value"}, val, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
  endtask

  task automatic set_tbl(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = d;
  endtask

  function automatic logic [15:0] rand_entry();
    int r;
    logic [15:0] e;
    r = $urandom_range(0, 9);
    if (r < 6) begin
      e = 16'($urandom);
      if (e[15:8] == 8'hF0) e[15:8] = 8'hF1;
    end else if (r < 8) begin
      e = {8'hF0, 8'($urandom_range(0, 3))};
    end else begin
      e = 16'hFFFF;
    end
    return e;
  endfunction

  // Called at a negedge; START is sampled on the following edge.
  task automatic do_run(input int mode, input int stall_n, input bit extra, input int gap,
                        input int pin_done, input int pin_p0, input int pin_p1);
    int s, r;
    i2c_mode = mode;
    s = cyc + 1;
    r = (stall_n > 0) ? s + stall_n : 0;
    build_model(s, r, mode);
    if (pin_done >= 0) check("model_done", run_done - s, pin_done);
    if (pin_p0 >= 0) check("model_p0", p_cyc[0] - s, pin_p0);
    if (pin_p1 >= 0) check("model_p1", p_cyc[1] - s, pin_p1);
    stall = (stall_n > 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < run_done + gap) begin
      if (stall && cyc >= r - 1) stall = 1'b0;
      start = extra && (cyc + 1 < run_done) && ($urandom_range(0, 5) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    stall = 1'b0;
    prev_fin = 1; prev_err = run_err ? 1 : 0; prev_cnt = n_comp;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    set_tbl(16'h1280, 16'hF002, 16'h1101, 16'hFFFF);
    fork
      compare_loop();
    join_none
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");
    prev_fin = 0; prev_err = 0; prev_cnt = 0;
    model_on = 1'b1;
    @(negedge clk);

    // Writes, 8-cycle delay, write, terminator.
    do_run(0, 0, 1'b0, 2, 47, 3, 31);
    // No ACK: abort 8 cycles after WAIT_ACK entry.
    do_run(1, 0, 1'b0, 2, 11, 3, -1);
    // No terminator: four writes then overrun.
    set_tbl(16'h1201, 16'h3456, 16'h7AA5, 16'h0B0C);
    do_run(0, 0, 1'b0, 3, 68, 3, 20);

    // Reset during WAIT_DONE of the first write, then replay from address 0.
    set_tbl(16'h1280, 16'hF002, 16'h1101, 16'hFFFF);
    i2c_mode = 0;
    s = cyc + 1;
    build_model(s, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < p_cyc[0] + 7) @(negedge clk);
    model_on = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("mid_reset");
    repeat (15) @(negedge clk);
    prev_fin = 0; prev_err = 0; prev_cnt = 0;
    run_s = 1 << 30;
    model_on = 1'b1;
    do_run(0, 0, 1'b0, 1, 47, 3, 31);

    // START while busy is ignored; START landing in DONE restarts.
    do_run(0, 0, 1'b1, 0, 47, 3, 31);
    do_run(0, 0, 1'b0, 2, 47, 3, 31);
    // READY low when ISSUE is reached.
    do_run(0, 10, 1'b0, 2, 54, 10, 38);
    // Transfer never completes.
    do_run(2, 0, 1'b0, 10, 38, 3, -1);

    for (int n = 0; n < 25; n++) begin
      int md, st;
      for (int i = 0; i < 4; i++) tbl[i] = rand_entry();
      md = 0;
      if ($urandom_range(0, 9) == 0) md = 1;
      else if ($urandom_range(0, 9) == 0) md = 2;
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 12)) : 0;
      do_run(md, st, 1'($urandom_range(0, 1)), (md == 2) ? 10 : int'($urandom_range(0, 3)), -1, -1, -1);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
